// File: rtl/ctrl_pkg.sv
// Shared encodings for the datapath sequencer: state enum, opcode/op values,
// ALU operation codes and instruction field positions.
package ctrl_pkg;

   typedef enum logic [2:0] {
      S_WAIT   = 3'd0,
      S_DECODE = 3'd1,
      S_GETA   = 3'd2,
      S_GETB   = 3'd3,
      S_EXEC   = 3'd4,
      S_WREG   = 3'd5,
      S_WIMM   = 3'd6,
      S_DONE   = 3'd7
   } state_t;

   localparam logic [2:0] OPC_MOV = 3'b110;
   localparam logic [2:0] OPC_ALU = 3'b101;

   localparam logic [1:0] OP_MOV_IMM = 2'b10;
   localparam logic [1:0] OP_MOV_REG = 2'b00;
   localparam logic [1:0] OP_ADD     = 2'b00;
   localparam logic [1:0] OP_CMP     = 2'b01;
   localparam logic [1:0] OP_AND     = 2'b10;
   localparam logic [1:0] OP_MVN     = 2'b11;

   localparam logic [1:0] ALU_ADD  = 2'b00;
   localparam logic [1:0] ALU_SUB  = 2'b01;
   localparam logic [1:0] ALU_AND  = 2'b10;
   localparam logic [1:0] ALU_NOTB = 2'b11;

   localparam int OPC_MSB = 15;
   localparam int OPC_LSB = 13;
   localparam int OP_MSB  = 12;
   localparam int OP_LSB  = 11;
   localparam int RN_MSB  = 10;
   localparam int RN_LSB  = 8;
   localparam int RD_MSB  = 7;
   localparam int RD_LSB  = 5;
   localparam int SH_MSB  = 4;
   localparam int SH_LSB  = 3;
   localparam int RM_MSB  = 2;
   localparam int RM_LSB  = 0;
   localparam int IMM_MSB = 7;
   localparam int IMM_LSB = 0;

   typedef struct packed {
      logic mov_imm;
      logic mov_reg;
      logic add;
      logic cmp;
      logic and_op;
      logic mvn;
   } iclass_t;

endpackage

// File: rtl/instr_decode.sv
// Combinational instruction decoder: splits IR into register/shift fields,
// extends imm8 and classifies the encoding.
module instr_decode
   import ctrl_pkg::*;
#(
   parameter logic SIGN_EXT_IMM = 1'b1
) (
   input  logic [15:0] ir,
   output logic [2:0]  rn,
   output logic [2:0]  rd,
   output logic [1:0]  sh,
   output logic [2:0]  rm,
   output logic [15:0] imm_ext,
   output iclass_t     cls,
   output logic        legal
);

   logic [2:0] opcode;
   logic [1:0] op;
   logic [7:0] imm8;

   assign opcode = ir[OPC_MSB:OPC_LSB];
   assign op     = ir[OP_MSB:OP_LSB];
   assign rn     = ir[RN_MSB:RN_LSB];
   assign rd     = ir[RD_MSB:RD_LSB];
   assign sh     = ir[SH_MSB:SH_LSB];
   assign rm     = ir[RM_MSB:RM_LSB];
   assign imm8   = ir[IMM_MSB:IMM_LSB];

   assign imm_ext = {{8{imm8[7] & SIGN_EXT_IMM}}, imm8};

   assign cls.mov_imm = (opcode == OPC_MOV) && (op == OP_MOV_IMM);
   assign cls.mov_reg = (opcode == OPC_MOV) && (op == OP_MOV_REG);
   assign cls.add     = (opcode == OPC_ALU) && (op == OP_ADD);
   assign cls.cmp     = (opcode == OPC_ALU) && (op == OP_CMP);
   assign cls.and_op  = (opcode == OPC_ALU) && (op == OP_AND);
   assign cls.mvn     = (opcode == OPC_ALU) && (op == OP_MVN);

   assign legal = |cls;

endmodule

// File: rtl/datapath_ctrl.sv
// Multi-cycle sequencer driving the register-file/shifter/ALU datapath strobes,
// one instruction per start/done handshake.
//
// state  | meaning
// WAIT   | idle, latch IR on start
// DECODE | classify IR, branch to first working state
// GETA   | read Rn into A
// GETB   | read Rm into B
// EXEC   | shift/ALU, load C (or status for CMP)
// WREG   | write result register to Rd
// WIMM   | write extended imm8 to Rn
// DONE   | done pulse, err if encoding was illegal
module datapath_ctrl
   import ctrl_pkg::*;
#(
   parameter logic SIGN_EXT_IMM = 1'b1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [15:0] instr,
   output logic        busy,
   output logic        done,
   output logic        err,
   output logic [2:0]  readnum,
   output logic        loada,
   output logic        loadb,
   output logic        asel,
   output logic        bsel,
   output logic [1:0]  shift,
   output logic [1:0]  ALUop,
   output logic        loadc,
   output logic        loads,
   output logic [2:0]  writenum,
   output logic        write,
   output logic        vsel,
   output logic [15:0] datapath_in
);

   state_t      state, state_nxt;
   logic [15:0] ir;
   logic [2:0]  rn, rd, rm;
   logic [1:0]  sh;
   logic [15:0] imm_ext;
   iclass_t     cls;
   logic        legal;

   instr_decode #(.SIGN_EXT_IMM(SIGN_EXT_IMM)) u_decode (
      .ir      (ir),
      .rn      (rn),
      .rd      (rd),
      .sh      (sh),
      .rm      (rm),
      .imm_ext (imm_ext),
      .cls     (cls),
      .legal   (legal)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_WAIT;
         ir    <= '0;
      end else begin
         state <= state_nxt;
         if (state == S_WAIT && start)
            ir <= instr;
      end
   end

   always_comb begin
      state_nxt   = state;
      busy        = (state != S_WAIT);
      done        = 1'b0;
      err         = 1'b0;
      readnum     = '0;
      loada       = 1'b0;
      loadb       = 1'b0;
      asel        = 1'b0;
      bsel        = 1'b0;
      shift       = '0;
      ALUop       = ALU_ADD;
      loadc       = 1'b0;
      loads       = 1'b0;
      writenum    = '0;
      write       = 1'b0;
      vsel        = 1'b0;
      datapath_in = '0;
      case (state)
         S_WAIT: begin
            if (start)
               state_nxt = S_DECODE;
         end
         S_DECODE: begin
            if (cls.mov_imm)
               state_nxt = S_WIMM;
            else if (cls.mov_reg || cls.mvn)
               state_nxt = S_GETB;
            else if (cls.add || cls.cmp || cls.and_op)
               state_nxt = S_GETA;
            else
               state_nxt = S_DONE;
         end
         S_GETA: begin
            readnum   = rn;
            loada     = 1'b1;
            state_nxt = S_GETB;
         end
         S_GETB: begin
            readnum   = rm;
            loadb     = 1'b1;
            state_nxt = S_EXEC;
         end
         S_EXEC: begin
            shift = sh;
            // MOV-reg and MVN only use the B path, so A is forced to zero
            asel  = cls.mov_reg || cls.mvn;
            if (cls.cmp)
               ALUop = ALU_SUB;
            else if (cls.and_op)
               ALUop = ALU_AND;
            else if (cls.mvn)
               ALUop = ALU_NOTB;
            else
               ALUop = ALU_ADD;
            if (cls.cmp) begin
               loads     = 1'b1;
               state_nxt = S_DONE;
            end else begin
               loadc     = 1'b1;
               state_nxt = S_WREG;
            end
         end
         S_WREG: begin
            writenum  = rd;
            write     = 1'b1;
            state_nxt = S_DONE;
         end
         S_WIMM: begin
            writenum    = rn;
            vsel        = 1'b1;
            write       = 1'b1;
            datapath_in = imm_ext;
            state_nxt   = S_DONE;
         end
         S_DONE: begin
            done      = 1'b1;
            err       = !legal;
            state_nxt = S_WAIT;
         end
         default: state_nxt = S_WAIT;
      endcase
   end

endmodule

// File: tb/tb_datapath_ctrl.sv
// Scoreboard bench for datapath_ctrl: stimulus pushes the expected per-instruction
// strobe trace, a negedge monitor accumulates the observed trace and checks it on done.
module tb_datapath_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [15:0] instr;
   logic        busy, done, err;
   logic [2:0]  readnum, writenum;
   logic        loada, loadb, asel, bsel, loadc, loads, write, vsel;
   logic [1:0]  shift, ALUop;
   logic [15:0] datapath_in;

   datapath_ctrl #(.SIGN_EXT_IMM(1'b1)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .instr       (instr),
      .busy        (busy),
      .done        (done),
      .err         (err),
      .readnum     (readnum),
      .loada       (loada),
      .loadb       (loadb),
      .asel        (asel),
      .bsel        (bsel),
      .shift       (shift),
      .ALUop       (ALUop),
      .loadc       (loadc),
      .loads       (loads),
      .writenum    (writenum),
      .write       (write),
      .vsel        (vsel),
      .datapath_in (datapath_in)
   );

   always #5 clk = ~clk;

   typedef struct {
      int lat;  int err;  int nwr;  int wnum; int vsel; int dpin;
      int nlc;  int nls;  int nla;  int ra;   int nlb;  int rb;
      int shf;  int alu;  int asel; int bsel; int leak;
   } trace_t;

   trace_t q[$];
   trace_t acc;
   int n_cmp = 0;
   int n_bad = 0;
   int cyc = 0;

   always @(posedge clk) cyc++;

   task automatic chk(input string nm, input int act, input int exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic fail(input string nm);
      n_cmp++;
      n_bad++;
      $display("FAIL %s: event not seen, expected it within bound", nm);
   endtask

   function automatic trace_t mk(int lat, int e, int nwr, int wnum, int vs, int dpin,
                                 int nlc, int nls, int nla, int ra, int nlb, int rb,
                                 int shf, int alu, int as);
      trace_t t;
      t.lat = lat; t.err = e; t.nwr = nwr; t.wnum = wnum; t.vsel = vs; t.dpin = dpin;
      t.nlc = nlc; t.nls = nls; t.nla = nla; t.ra = ra; t.nlb = nlb; t.rb = rb;
      t.shf = shf; t.alu = alu; t.asel = as; t.bsel = 0; t.leak = 0;
      return t;
   endfunction

   function automatic trace_t clr();
      return mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
   endfunction

   // Monitor: observed trace per instruction, compared against the queue head on done.
   always @(negedge clk) begin
      trace_t e;
      if (!rst_n) begin
         chk("rst_quiet", {busy, done, err, write, loadc, loads, loada, loadb}, 0);
         acc = clr();
      end else if (!busy) begin
         acc = clr();
      end else begin
         acc.lat++;
         if (err) acc.err++;
         if (write) begin
            acc.nwr++; acc.wnum = writenum; acc.vsel = vsel; acc.dpin = datapath_in;
         end
         if (loadc) acc.nlc++;
         if (loads) acc.nls++;
         if (loadc || loads) begin
            acc.shf = shift; acc.alu = ALUop; acc.asel = asel;
         end
         if (loada) begin acc.nla++; acc.ra = readnum; end
         if (loadb) begin acc.nlb++; acc.rb = readnum; end
         if (bsel) acc.bsel++;
         if (datapath_in != 16'h0 && !(write && vsel)) acc.leak++;
         if (done) begin
            if (q.size() == 0) begin
               fail("unexpected_done");
            end else begin
               e = q.pop_front();
               chk("latency",   acc.lat,  e.lat);
               chk("err",       acc.err,  e.err);
               chk("n_write",   acc.nwr,  e.nwr);
               chk("writenum",  acc.wnum, e.wnum);
               chk("vsel",      acc.vsel, e.vsel);
               chk("dp_in",     acc.dpin, e.dpin);
               chk("n_loadc",   acc.nlc,  e.nlc);
               chk("n_loads",   acc.nls,  e.nls);
               chk("n_loada",   acc.nla,  e.nla);
               chk("readnum_a", acc.ra,   e.ra);
               chk("n_loadb",   acc.nlb,  e.nlb);
               chk("readnum_b", acc.rb,   e.rb);
               chk("shift",     acc.shf,  e.shf);
               chk("aluop",     acc.alu,  e.alu);
               chk("asel",      acc.asel, e.asel);
               chk("bsel",      acc.bsel, e.bsel);
               chk("dp_in_leak", acc.leak, e.leak);
            end
         end
      end
   end

   task automatic issue(input logic [15:0] w, input bit push, input trace_t e);
      int t = 0;
      while (busy && t < 50) begin
         @(posedge clk); #1;
         t++;
      end
      if (busy) begin
         fail("issue_idle_timeout");
         return;
      end
      if (push) q.push_back(e);
      start = 1'b1;
      instr = w;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   initial begin
      int t;
      int nd;
      int d_cyc[3];
      rst_n = 1'b0;
      start = 1'b0;
      instr = 16'h0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_busy", busy, 0);
      chk("reset_strobes", {done, err, readnum, loada, loadb, asel, bsel, shift, ALUop,
                            loadc, loads, writenum, write, vsel}, 0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      //      lat err nwr wn vs dpin   nlc nls nla ra nlb rb shf alu asel
      issue(16'hD3FE, 1, mk(3, 0, 1, 3, 1, 65534, 0, 0, 0, 0, 0, 0, 0, 0, 0)); // MOV R3,#-2
      issue(16'hA148, 1, mk(6, 0, 1, 2, 0, 0,     1, 0, 1, 1, 1, 0, 1, 0, 0)); // ADD R2,R1,R0<<1
      issue(16'hAD05, 1, mk(5, 0, 0, 0, 0, 0,     0, 1, 1, 5, 1, 5, 0, 1, 0)); // CMP R5,R5
      issue(16'hE000, 1, mk(2, 1, 0, 0, 0, 0,     0, 0, 0, 0, 0, 0, 0, 0, 0)); // illegal opcode
      issue(16'hC096, 1, mk(5, 0, 1, 4, 0, 0,     1, 0, 0, 0, 1, 6, 2, 0, 1)); // MOV R4,R6<<2
      issue(16'hB27D, 1, mk(6, 0, 1, 3, 0, 0,     1, 0, 1, 2, 1, 5, 3, 2, 0)); // AND R3,R2,R5<<3
      issue(16'hD735, 1, mk(3, 0, 1, 7, 1, 53,    0, 0, 0, 0, 0, 0, 0, 0, 0)); // MOV R7,#0x35
      issue(16'hC800, 1, mk(2, 1, 0, 0, 0, 0,     0, 0, 0, 0, 0, 0, 0, 0, 0)); // MOV op=01 illegal
      issue(16'hB8E1, 1, mk(5, 0, 1, 7, 0, 0,     1, 0, 0, 0, 1, 1, 0, 3, 1)); // MVN R7,R1

      // Abort an ADD in EXEC with an asynchronous reset; nothing is queued for it.
      issue(16'hA148, 0, clr());
      t = 0;
      do begin
         @(negedge clk);
         t++;
      end while (!loadc && t < 20);
      if (!loadc) fail("abort_reach_exec");
      #2 rst_n = 1'b0;
      #1;
      chk("abort_busy", busy, 0);
      chk("abort_strobes", {done, err, readnum, loada, loadb, asel, bsel, shift, ALUop,
                            loadc, loads, writenum, write, vsel}, 0);
      chk("abort_dp_in", datapath_in, 0);
      repeat (2) @(negedge clk);
      #2 rst_n = 1'b1;
      nd = 0;
      repeat (4) begin
         @(negedge clk);
         if (done || write || busy) nd++;
      end
      chk("abort_no_resume", nd, 0);
      @(posedge clk); #1;
      issue(16'hD735, 1, mk(3, 0, 1, 7, 1, 53, 0, 0, 0, 0, 0, 0, 0, 0, 0));

      // start held high: MVN issues every 6 cycles, never accepted in DONE.
      t = 0;
      while (busy && t < 50) begin
         @(posedge clk); #1;
         t++;
      end
      for (int k = 0; k < 3; k++)
         q.push_back(mk(5, 0, 1, 7, 0, 0, 1, 0, 0, 0, 1, 1, 0, 3, 1));
      start = 1'b1;
      instr = 16'hB8E1;
      for (int k = 0; k < 3; k++) begin
         t = 0;
         do begin
            @(negedge clk);
            t++;
         end while (!done && t < 20);
         if (!done) fail("b2b_done");
         d_cyc[k] = cyc;
      end
      start = 1'b0;
      chk("b2b_interval_1", d_cyc[1] - d_cyc[0], 6);
      chk("b2b_interval_2", d_cyc[2] - d_cyc[1], 6);
      nd = 0;
      repeat (8) begin
         @(negedge clk);
         if (busy) nd++;
      end
      chk("b2b_stops", nd, 0);

      t = 0;
      while (q.size() != 0 && t < 100) begin
         @(posedge clk);
         t++;
      end
      chk("queue_drained", q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
